// File: rtl/leaf_out_arbiter_if.sv
// Leaf output-side bus bundle: user stream payload/valid/ack plus the
// BFT-facing packet. The master side is the user kernel and packet consumer;
// the slave side is the arbiter.
interface leaf_out_arbiter_if #(
  parameter int NUM_OUT_PORTS = 7,
  parameter int PAYLOAD_BITS  = 32,
  parameter int PACKET_BITS   = 49
);
  logic [NUM_OUT_PORTS*PAYLOAD_BITS-1:0] din_user;
  logic [NUM_OUT_PORTS-1:0]              vld_user;
  logic [NUM_OUT_PORTS-1:0]              ack_user;
  logic [PACKET_BITS-1:0]                dout_pkt;

  modport master (
    output din_user,
    output vld_user,
    input  ack_user,
    input  dout_pkt
  );

  modport slave (
    input  din_user,
    input  vld_user,
    output ack_user,
    output dout_pkt
  );
endinterface

// File: rtl/leaf_out_arbiter.sv
// leaf_out_arbiter: shares the single leaf-to-BFT packet output among
// NUM_OUT_PORTS user output streams. Each port carries a destination
// (leaf, port), a credit counter tracking free space at the remote end and a
// sequence counter. One round-robin grant per cycle; packet and ack appear
// one cycle after the request is seen.
// Optional per-port grant statistics: define LEAF_OUT_ARB_STATS_EN.
module leaf_out_arbiter #(
  parameter int NUM_OUT_PORTS = 7,
  parameter int PAYLOAD_BITS  = 32,
  parameter int NUM_LEAF_BITS = 5,
  parameter int NUM_PORT_BITS = 4,
  parameter int NUM_ADDR_BITS = 7,
  parameter int PACKET_BITS   = 49,
  parameter int CREDIT_BITS   = 8,
  parameter int CREDIT_INIT   = 64
) (
  input  logic                     clk,
  input  logic                     reset_n,
  leaf_out_arbiter_if.slave        bus,
  input  logic                     cfg_we,
  input  logic [NUM_PORT_BITS-1:0] cfg_port,
  input  logic [NUM_LEAF_BITS-1:0] cfg_leaf,
  input  logic [NUM_PORT_BITS-1:0] cfg_dport,
  input  logic                     credit_vld,
  input  logic [NUM_PORT_BITS-1:0] credit_port,
  input  logic [CREDIT_BITS-1:0]   credit_amt,
  input  logic                     stall
`ifdef LEAF_OUT_ARB_STATS_EN
  ,
  input  logic [NUM_PORT_BITS-1:0] stat_sel,
  input  logic                     stat_clr,
  output logic [15:0]              stat_cnt
`endif
);

  localparam int PW = NUM_PORT_BITS;
  localparam logic [CREDIT_BITS-1:0] CREDIT_MAX = '1;
  localparam logic [CREDIT_BITS-1:0] CREDIT_RST = CREDIT_BITS'(CREDIT_INIT);

  logic [NUM_OUT_PORTS-1:0] cfg_valid;
  logic [NUM_LEAF_BITS-1:0] dest_leaf   [NUM_OUT_PORTS];
  logic [NUM_PORT_BITS-1:0] dest_port   [NUM_OUT_PORTS];
  logic [NUM_ADDR_BITS-1:0] seq_cnt     [NUM_OUT_PORTS];
  logic [CREDIT_BITS-1:0]   credit      [NUM_OUT_PORTS];
  logic [CREDIT_BITS-1:0]   credit_next [NUM_OUT_PORTS];

  logic [PW-1:0]            rr_ptr;
  logic [PW-1:0]            rr_ptr_next;
  logic [NUM_OUT_PORTS-1:0] eligible;
  logic [NUM_OUT_PORTS-1:0] grant_oh;
  logic                     grant_vld;
  logic [NUM_OUT_PORTS-1:0] ack_q;
  logic [PACKET_BITS-1:0]   pkt_next;
  logic [PACKET_BITS-1:0]   pkt_q;

  assign bus.ack_user = ack_q;
  assign bus.dout_pkt = pkt_q;

  // A port may compete when it has data, a destination, remote space, no
  // stall, and was not acked this cycle (the user may still be holding vld).
  // NOTE: every always_comb output gets a default before any conditional
  // assignment, so no path leaves a value held and no latch is inferred.
  always_comb begin
    eligible = '0;
    for (int i = 0; i < NUM_OUT_PORTS; i++) begin
      eligible[i] = bus.vld_user[i] & cfg_valid[i] & (credit[i] != '0) &
                    ~stall & ~ack_q[i];
    end
  end

  // Round-robin search from rr_ptr upward with wrap; first eligible wins.
  always_comb begin
    int pos;
    pos         = 0;
    grant_vld   = 1'b0;
    grant_oh    = '0;
    rr_ptr_next = rr_ptr;
    for (int k = 0; k < NUM_OUT_PORTS; k++) begin
      pos = int'(rr_ptr) + k;
      if (pos >= NUM_OUT_PORTS) pos = pos - NUM_OUT_PORTS;
      for (int i = 0; i < NUM_OUT_PORTS; i++) begin
        if (!grant_vld && pos == i && eligible[i]) begin
          grant_vld   = 1'b1;
          grant_oh[i] = 1'b1;
          rr_ptr_next = (i == NUM_OUT_PORTS - 1) ? '0 : PW'(i + 1);
        end
      end
    end
  end

  // Assemble the packet for the granted port; all zeros when idle.
  always_comb begin
    pkt_next = '0;
    for (int i = 0; i < NUM_OUT_PORTS; i++) begin
      if (grant_oh[i]) begin
        pkt_next = {1'b1, dest_leaf[i], dest_port[i], seq_cnt[i],
                    bus.din_user[i*PAYLOAD_BITS +: PAYLOAD_BITS]};
      end
    end
  end

  // Credit update: add any return, subtract a grant, then saturate. The
  // extra bit holds the carry; a grant implies credit >= 1, so no underflow.
  always_comb begin
    logic [CREDIT_BITS:0] sum;
    sum = '0;
    for (int i = 0; i < NUM_OUT_PORTS; i++) begin
      sum = {1'b0, credit[i]};
      if (credit_vld && credit_port == PW'(i)) sum = sum + {1'b0, credit_amt};
      if (grant_oh[i]) sum = sum - (CREDIT_BITS+1)'(1);
      credit_next[i] = (sum > {1'b0, CREDIT_MAX}) ? CREDIT_MAX : sum[CREDIT_BITS-1:0];
    end
  end

  // Per-port destination, credit and sequence state. Out-of-range config or
  // credit port indices match no slot and are dropped.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  // NOTE: these per-port arrays are reset because eligibility and packet
  // contents depend on them immediately after reset; they are flops, not RAM.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cfg_valid <= '0;
      for (int i = 0; i < NUM_OUT_PORTS; i++) begin
        dest_leaf[i] <= '0;
        dest_port[i] <= '0;
        seq_cnt[i]   <= '0;
        credit[i]    <= CREDIT_RST;
      end
    end else begin
      for (int i = 0; i < NUM_OUT_PORTS; i++) begin
        if (cfg_we && cfg_port == PW'(i)) begin
          cfg_valid[i] <= 1'b1;
          dest_leaf[i] <= cfg_leaf;
          dest_port[i] <= cfg_dport;
        end
        credit[i] <= credit_next[i];
        if (grant_oh[i]) seq_cnt[i] <= seq_cnt[i] + 1'b1;
      end
    end
  end

  // Registered ack pulse, packet output and round-robin pointer.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ack_q  <= '0;
      pkt_q  <= '0;
      rr_ptr <= '0;
    end else begin
      ack_q  <= grant_oh;
      pkt_q  <= pkt_next;
      rr_ptr <= rr_ptr_next;
    end
  end

`ifdef LEAF_OUT_ARB_STATS_EN
  logic [15:0] stat_q [NUM_OUT_PORTS];

  // Saturating per-port grant counters with a registered readout; a clear
  // wins over a same-cycle grant.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stat_cnt <= '0;
      for (int i = 0; i < NUM_OUT_PORTS; i++) stat_q[i] <= '0;
    end else begin
      stat_cnt <= '0;
      for (int i = 0; i < NUM_OUT_PORTS; i++) begin
        if (stat_clr) begin
          stat_q[i] <= '0;
        end else if (grant_oh[i] && stat_q[i] != 16'hFFFF) begin
          stat_q[i] <= stat_q[i] + 16'd1;
        end
        if (stat_sel == PW'(i)) stat_cnt <= stat_q[i];
      end
    end
  end
`endif

endmodule

// File: tb/tb_leaf_out_arbiter.sv
// Directed testbench for leaf_out_arbiter. Inputs change and outputs are
// sampled on the falling clock edge, away from the active rising edge.
module tb_leaf_out_arbiter;
  localparam int N   = 7;
  localparam int PB  = 32;
  localparam int LB  = 5;
  localparam int PTB = 4;
  localparam int AB  = 7;
  localparam int PKB = 49;
  localparam int CB  = 8;
  localparam int CI  = 64;

  logic           clk;
  logic           reset_n;
  logic           cfg_we;
  logic [PTB-1:0] cfg_port;
  logic [LB-1:0]  cfg_leaf;
  logic [PTB-1:0] cfg_dport;
  logic           credit_vld;
  logic [PTB-1:0] credit_port;
  logic [CB-1:0]  credit_amt;
  logic           stall;
`ifdef LEAF_OUT_ARB_STATS_EN
  logic [PTB-1:0] stat_sel;
  logic           stat_clr;
  logic [15:0]    stat_cnt;
`endif

  int checks;
  int errors;

  leaf_out_arbiter_if #(.NUM_OUT_PORTS(N), .PAYLOAD_BITS(PB), .PACKET_BITS(PKB)) bus ();

  leaf_out_arbiter #(
    .NUM_OUT_PORTS(N), .PAYLOAD_BITS(PB), .NUM_LEAF_BITS(LB), .NUM_PORT_BITS(PTB),
    .NUM_ADDR_BITS(AB), .PACKET_BITS(PKB), .CREDIT_BITS(CB), .CREDIT_INIT(CI)
  ) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus),
    .cfg_we(cfg_we), .cfg_port(cfg_port), .cfg_leaf(cfg_leaf), .cfg_dport(cfg_dport),
    .credit_vld(credit_vld), .credit_port(credit_port), .credit_amt(credit_amt),
    .stall(stall)
`ifdef LEAF_OUT_ARB_STATS_EN
    , .stat_sel(stat_sel), .stat_clr(stat_clr), .stat_cnt(stat_cnt)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [PKB-1:0] mk_pkt(input logic [LB-1:0] leaf, input logic [PTB-1:0] dport,
                                            input logic [AB-1:0] seq, input logic [PB-1:0] data);
    return {1'b1, leaf, dport, seq, data};
  endfunction

  task automatic idle_inputs();
    cfg_we       = 1'b0;
    cfg_port     = '0;
    cfg_leaf     = '0;
    cfg_dport    = '0;
    credit_vld   = 1'b0;
    credit_port  = '0;
    credit_amt   = '0;
    stall        = 1'b0;
    bus.vld_user = '0;
    bus.din_user = '0;
`ifdef LEAF_OUT_ARB_STATS_EN
    stat_sel = '0;
    stat_clr = 1'b0;
`endif
  endtask

  task automatic do_reset();
    idle_inputs();
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic configure(input int port, input logic [LB-1:0] leaf, input logic [PTB-1:0] dport);
    cfg_we    = 1'b1;
    cfg_port  = PTB'(port);
    cfg_leaf  = leaf;
    cfg_dport = dport;
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  task automatic set_payload(input int port, input logic [PB-1:0] data);
    bus.din_user[port*PB +: PB] = data;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset_n = 1'b1;
    #1 reset_n = 1'b0;
    #1;
    checks++;
    if (bus.ack_user !== '0) begin errors++; $display("FAIL reset_ack got %b want 0", bus.ack_user); end
    checks++;
    if (bus.dout_pkt !== '0) begin errors++; $display("FAIL reset_dout got %h want 0", bus.dout_pkt); end
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    bus.vld_user = '1;
    repeat (3) @(negedge clk);
    checks++;
    if (bus.ack_user !== '0) begin errors++; $display("FAIL unconfigured_ack got %b want 0", bus.ack_user); end
    checks++;
    if (bus.dout_pkt !== '0) begin errors++; $display("FAIL unconfigured_dout got %h want 0", bus.dout_pkt); end
    bus.vld_user = '0;
  endtask

  task automatic test_single();
    do_reset();
    configure(2, 5'd5, 4'd3);
    set_payload(2, 32'hDEADBEEF);
    bus.vld_user = 7'b0000100;
    @(negedge clk);
    checks++;
    if (bus.ack_user !== 7'b0000100) begin errors++; $display("FAIL single_ack got %b want 0000100", bus.ack_user); end
    checks++;
    if (bus.dout_pkt !== mk_pkt(5'd5, 4'd3, 7'd0, 32'hDEADBEEF)) begin
      errors++; $display("FAIL single_dout got %h want %h", bus.dout_pkt, mk_pkt(5'd5, 4'd3, 7'd0, 32'hDEADBEEF));
    end
    bus.vld_user = '0;
    @(negedge clk);
    checks++;
    if (bus.ack_user !== '0) begin errors++; $display("FAIL single_ack_pulse got %b want 0", bus.ack_user); end
    checks++;
    if (bus.dout_pkt !== '0) begin errors++; $display("FAIL single_idle_dout got %h want 0", bus.dout_pkt); end
  endtask

  task automatic test_round_robin();
    int order [3];
    int p;
    int s;
    logic [N-1:0]   exp_ack;
    logic [PKB-1:0] exp_pkt;
    order = '{0, 3, 6};
    do_reset();
    for (int j = 0; j < 3; j++) begin
      configure(order[j], LB'(order[j]), PTB'(order[j] + 1));
      set_payload(order[j], 32'hA000_0000 + 32'(order[j]));
    end
    bus.vld_user = 7'b1001001;
    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      p = order[c % 3];
      s = c / 3;
      exp_ack    = '0;
      exp_ack[p] = 1'b1;
      exp_pkt    = mk_pkt(LB'(p), PTB'(p + 1), AB'(s), 32'hA000_0000 + 32'(p));
      checks++;
      if (bus.ack_user !== exp_ack) begin errors++; $display("FAIL rr_ack[%0d] got %b want %b", c, bus.ack_user, exp_ack); end
      checks++;
      if (bus.dout_pkt !== exp_pkt) begin errors++; $display("FAIL rr_dout[%0d] got %h want %h", c, bus.dout_pkt, exp_pkt); end
    end
    bus.vld_user = '0;
    @(negedge clk);
    checks++;
    if (bus.dout_pkt !== '0) begin errors++; $display("FAIL rr_idle got %h want 0", bus.dout_pkt); end
    // Rewriting a port's destination keeps its sequence counter.
    configure(0, 5'd9, 4'd2);
    bus.vld_user = 7'b0000001;
    @(negedge clk);
    exp_pkt = mk_pkt(5'd9, 4'd2, 7'd3, 32'hA000_0000);
    checks++;
    if (bus.dout_pkt !== exp_pkt) begin errors++; $display("FAIL rr_reconfig got %h want %h", bus.dout_pkt, exp_pkt); end
    bus.vld_user = '0;
    @(negedge clk);
  endtask

  task automatic test_credit_exhaust();
    int n;
    logic [AB-1:0] last_seq;
    logic [AB-1:0] first_seq;
    do_reset();
    configure(1, 5'd7, 4'd1);
    set_payload(1, 32'h0000_1111);
    bus.vld_user = 7'b0000010;
    n = 0;
    last_seq = '0;
    for (int c = 0; c < 160; c++) begin
      @(negedge clk);
      if (bus.ack_user[1]) begin n++; last_seq = bus.dout_pkt[38:32]; end
    end
    checks++;
    if (n != 64) begin errors++; $display("FAIL credit_exhaust_count got %0d want 64", n); end
    checks++;
    if (last_seq !== 7'd63) begin errors++; $display("FAIL credit_exhaust_last_seq got %0d want 63", last_seq); end
    checks++;
    if (bus.dout_pkt !== '0) begin errors++; $display("FAIL credit_silent got %h want 0", bus.dout_pkt); end
    credit_port = 4'd1;
    credit_amt  = 8'd2;
    credit_vld  = 1'b1;
    n = 0;
    first_seq = '0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      credit_vld = 1'b0;
      if (bus.ack_user[1]) begin
        if (n == 0) first_seq = bus.dout_pkt[38:32];
        n++;
      end
    end
    checks++;
    if (n != 2) begin errors++; $display("FAIL credit_return_count got %0d want 2", n); end
    checks++;
    if (first_seq !== 7'd64) begin errors++; $display("FAIL credit_return_seq got %0d want 64", first_seq); end
`ifdef LEAF_OUT_ARB_STATS_EN
    stat_sel = 4'd1;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (stat_cnt !== 16'd66) begin errors++; $display("FAIL stat_count got %0d want 66", stat_cnt); end
`endif
    bus.vld_user = '0;
  endtask

  task automatic test_credit_saturate();
    int n;
    logic [AB-1:0] wrap_seq;
    do_reset();
    configure(4, 5'd2, 4'd6);
    set_payload(4, 32'h4444_0000);
    credit_port = 4'd4;
    credit_amt  = 8'd255;
    credit_vld  = 1'b1;
    @(negedge clk);
    // Credit is now saturated at 255; return 10 on the same edge as a grant.
    credit_amt   = 8'd10;
    bus.vld_user = 7'b0010000;
    @(negedge clk);
    credit_vld = 1'b0;
    checks++;
    if (bus.ack_user !== 7'b0010000) begin errors++; $display("FAIL sat_first_ack got %b want 0010000", bus.ack_user); end
    n = 1;
    wrap_seq = 7'h7F;
    for (int c = 0; c < 560; c++) begin
      @(negedge clk);
      if (bus.ack_user[4]) begin
        if (n == 128) wrap_seq = bus.dout_pkt[38:32];
        n++;
      end
    end
    checks++;
    if (n != 256) begin errors++; $display("FAIL sat_total_packets got %0d want 256", n); end
    checks++;
    if (wrap_seq !== 7'd0) begin errors++; $display("FAIL seq_wrap got %0d want 0", wrap_seq); end
    bus.vld_user = '0;
  endtask

  task automatic test_stall();
    do_reset();
    configure(1, 5'd1, 4'd1);
    configure(5, 5'd5, 4'd5);
    set_payload(1, 32'h0000_0011);
    set_payload(5, 32'h0000_0055);
    bus.vld_user = 7'b0100010;
    @(negedge clk);
    checks++;
    if (bus.ack_user !== 7'b0000010) begin errors++; $display("FAIL stall_pre_ack got %b want 0000010", bus.ack_user); end
    stall = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++;
      if (bus.ack_user !== '0) begin errors++; $display("FAIL stall_ack[%0d] got %b want 0", c, bus.ack_user); end
      checks++;
      if (bus.dout_pkt !== '0) begin errors++; $display("FAIL stall_dout[%0d] got %h want 0", c, bus.dout_pkt); end
    end
    stall = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.dout_pkt !== mk_pkt(5'd5, 4'd5, 7'd0, 32'h55)) begin
      errors++; $display("FAIL stall_resume_first got %h want %h", bus.dout_pkt, mk_pkt(5'd5, 4'd5, 7'd0, 32'h55));
    end
    @(negedge clk);
    checks++;
    if (bus.dout_pkt !== mk_pkt(5'd1, 4'd1, 7'd1, 32'h11)) begin
      errors++; $display("FAIL stall_resume_second got %h want %h", bus.dout_pkt, mk_pkt(5'd1, 4'd1, 7'd1, 32'h11));
    end
    bus.vld_user = '0;
  endtask

  task automatic test_reset_midstream();
    int busy;
    int n;
    int stray;
    do_reset();
    configure(0, 5'd3, 4'd4);
    configure(2, 5'd6, 4'd7);
    set_payload(0, 32'h0000_00A0);
    set_payload(2, 32'h0000_00A2);
    bus.vld_user = 7'b0000101;
    repeat (3) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (bus.ack_user !== '0) begin errors++; $display("FAIL midreset_ack got %b want 0", bus.ack_user); end
    checks++;
    if (bus.dout_pkt !== '0) begin errors++; $display("FAIL midreset_dout got %h want 0", bus.dout_pkt); end
    @(negedge clk);
    reset_n = 1'b1;
    busy = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (bus.ack_user !== '0 || bus.dout_pkt !== '0) busy++;
    end
    checks++;
    if (busy != 0) begin errors++; $display("FAIL midreset_unconfigured got %0d busy cycles want 0", busy); end
    configure(0, 5'd3, 4'd4);
    @(negedge clk);
    checks++;
    if (bus.dout_pkt !== mk_pkt(5'd3, 4'd4, 7'd0, 32'hA0)) begin
      errors++; $display("FAIL midreset_seq got %h want %h", bus.dout_pkt, mk_pkt(5'd3, 4'd4, 7'd0, 32'hA0));
    end
    n = bus.ack_user[0] ? 1 : 0;
    stray = 0;
    for (int c = 0; c < 150; c++) begin
      @(negedge clk);
      if (bus.ack_user[0]) n++;
      if (bus.ack_user[2]) stray++;
    end
    checks++;
    if (n != 64) begin errors++; $display("FAIL midreset_credit got %0d packets want 64", n); end
    checks++;
    if (stray != 0) begin errors++; $display("FAIL midreset_port2 got %0d acks want 0", stray); end
    bus.vld_user = '0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_single();
    test_round_robin();
    test_credit_exhaust();
    test_credit_saturate();
    test_stall();
    test_reset_midstream();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
